// File: rtl/cordic_req_sched.sv
// cordic_req_sched
//   Request scheduler and result collector wrapped around cordic_top.
//   Requests are buffered in an input FIFO and issued one per cycle into the
//   core. A latency-matched delay line carries tag/mode alongside each
//   operation. Results are collected into an output FIFO and re-joined with
//   their tag/mode. Issue is credit-limited so the output FIFO can never
//   overflow, whatever the downstream backpressure.
//
//   Optional feature macro: CORDIC_SCHED_BADMODE_EN
//     defined   : adds sticky output bad_mode; requests with mode 0 or 3 are
//                 handshaken but dropped.
//     undefined : every mode is enqueued and issued.
module cordic_req_sched #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16,
    parameter int TAG_WIDTH = 4,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 8,
    parameter int LAT       = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    // request side
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [1:0]           s_mode,
    input  logic [IN_WIDTH-1:0]  s_x,
    input  logic [IN_WIDTH-1:0]  s_y,
    input  logic [IN_WIDTH-1:0]  s_z,
    input  logic [TAG_WIDTH-1:0] s_tag,
    // cordic_top side
    output logic                 c_en,
    output logic [1:0]           c_mode,
    output logic [IN_WIDTH-1:0]  c_x,
    output logic [IN_WIDTH-1:0]  c_y,
    output logic [IN_WIDTH-1:0]  c_z,
    input  logic                 c_ready,
    input  logic [OUT_WIDTH-1:0] c_r,
    input  logic [OUT_WIDTH-1:0] c_a,
    // result side
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_r,
    output logic [OUT_WIDTH-1:0] m_a,
    output logic [TAG_WIDTH-1:0] m_tag,
    output logic [1:0]           m_mode,
    // status
    output logic                 busy,
    output logic                 err_sync
`ifdef CORDIC_SCHED_BADMODE_EN
    ,
    output logic                 bad_mode
`endif
);

    localparam int IPW   = $clog2(IN_DEPTH);
    localparam int ICW   = $clog2(IN_DEPTH + 1);
    localparam int OPW   = $clog2(OUT_DEPTH);
    localparam int OCW   = $clog2(OUT_DEPTH + 1);
    localparam int QW    = $clog2(LAT + 1);
    localparam int REQ_W = 2 + 3 * IN_WIDTH + TAG_WIDTH;
    localparam int RES_W = 2 * OUT_WIDTH + TAG_WIDTH + 2;

    localparam logic [ICW-1:0] IN_FULL_CNT = ICW'(IN_DEPTH);
    localparam logic [OCW:0]   CREDIT_MAX  = (OCW + 1)'(OUT_DEPTH);

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [REQ_W-1:0]     r_in_mem [IN_DEPTH];
    logic [IPW-1:0]       r_in_wr;
    logic [IPW-1:0]       r_in_rd;
    logic [ICW-1:0]       r_in_cnt;
    logic                 w_in_empty;
    logic                 w_in_full;
    logic                 w_in_push;
    logic                 w_in_pop;
    logic                 w_mode_ok;
    logic [REQ_W-1:0]     w_in_wdata;
    logic [1:0]           w_hd_mode;
    logic [IN_WIDTH-1:0]  w_hd_x;
    logic [IN_WIDTH-1:0]  w_hd_y;
    logic [IN_WIDTH-1:0]  w_hd_z;
    logic [TAG_WIDTH-1:0] w_hd_tag;

    // ------------------------------------------------------------------
    // Issue / credit / delay line
    // ------------------------------------------------------------------
    logic                 r_c_en;
    logic [1:0]           r_c_mode;
    logic [IN_WIDTH-1:0]  r_c_x;
    logic [IN_WIDTH-1:0]  r_c_y;
    logic [IN_WIDTH-1:0]  r_c_z;
    logic [OCW-1:0]       r_inflight;
    logic                 w_credit;
    logic                 w_issue;
    logic                 r_dl_vld_p  [0:LAT];
    logic [TAG_WIDTH-1:0] r_dl_tag_p  [0:LAT];
    logic [1:0]           r_dl_mode_p [0:LAT];
    logic                 w_exit_vld;
    logic [QW-1:0]        r_quiet;
    logic                 w_sync_bad;
    logic                 r_err_sync;

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [RES_W-1:0]     r_out_mem [OUT_DEPTH];
    logic [OPW-1:0]       r_out_wr;
    logic [OPW-1:0]       r_out_rd;
    logic [OCW-1:0]       r_out_cnt;
    logic                 w_out_empty;
    logic                 w_out_push;
    logic                 w_out_pop;
    logic [RES_W-1:0]     w_out_wdata;
    logic [OUT_WIDTH-1:0] w_oh_r;
    logic [OUT_WIDTH-1:0] w_oh_a;
    logic [TAG_WIDTH-1:0] w_oh_tag;
    logic [1:0]           w_oh_mode;

`ifdef CORDIC_SCHED_BADMODE_EN
    logic                 r_bad_mode;
    assign w_mode_ok = (s_mode == 2'd1) || (s_mode == 2'd2);
    assign bad_mode  = r_bad_mode;
`else
    assign w_mode_ok = 1'b1;
`endif

    // Input side handshake; rst forces s_ready low while reset is held.
    assign w_in_empty = (r_in_cnt == '0);
    assign w_in_full  = (r_in_cnt == IN_FULL_CNT);
    assign s_ready    = !rst && !w_in_full;
    assign w_in_push  = s_valid && s_ready && w_mode_ok;
    assign w_in_wdata = {s_mode, s_x, s_y, s_z, s_tag};
    assign {w_hd_mode, w_hd_x, w_hd_y, w_hd_z, w_hd_tag} = r_in_mem[r_in_rd];

    // Credit counts results already buffered plus operations still in the
    // core, so every issued operation owns an output FIFO slot.
    assign w_credit = ({1'b0, r_out_cnt} + {1'b0, r_inflight}) < CREDIT_MAX;
    assign w_issue  = !w_in_empty && w_credit;
    assign w_in_pop = w_issue;

    // Input FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_wr  <= '0;
            r_in_rd  <= '0;
            r_in_cnt <= '0;
        end else begin
            if (w_in_push) r_in_wr <= r_in_wr + IPW'(1);
            if (w_in_pop)  r_in_rd <= r_in_rd + IPW'(1);
            if (w_in_push && !w_in_pop)
                r_in_cnt <= r_in_cnt + ICW'(1);
            else if (!w_in_push && w_in_pop)
                r_in_cnt <= r_in_cnt - ICW'(1);
        end
    end

    // Input FIFO storage (data only, no reset needed).
    always_ff @(posedge clk) begin
        if (w_in_push) r_in_mem[r_in_wr] <= w_in_wdata;
    end

    // Issue register: drive the core with the popped head, zeros when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_en   <= 1'b0;
            r_c_mode <= '0;
            r_c_x    <= '0;
            r_c_y    <= '0;
            r_c_z    <= '0;
        end else begin
            r_c_en   <= w_issue;
            r_c_mode <= w_issue ? w_hd_mode : '0;
            r_c_x    <= w_issue ? w_hd_x    : '0;
            r_c_y    <= w_issue ? w_hd_y    : '0;
            r_c_z    <= w_issue ? w_hd_z    : '0;
        end
    end

    assign c_en   = r_c_en;
    assign c_mode = r_c_mode;
    assign c_x    = r_c_x;
    assign c_y    = r_c_y;
    assign c_z    = r_c_z;

    // Delay line valid bits: stage 0 loads together with c_en, stage LAT
    // lines up with the core's ready_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= LAT; k++) r_dl_vld_p[k] <= 1'b0;
        end else begin
            r_dl_vld_p[0] <= w_issue;
            for (int k = 1; k <= LAT; k++) r_dl_vld_p[k] <= r_dl_vld_p[k-1];
        end
    end

    // Delay line tag/mode payload, qualified by the valid bits above.
    always_ff @(posedge clk) begin
        r_dl_tag_p[0]  <= w_hd_tag;
        r_dl_mode_p[0] <= w_hd_mode;
        for (int k = 1; k <= LAT; k++) begin
            r_dl_tag_p[k]  <= r_dl_tag_p[k-1];
            r_dl_mode_p[k] <= r_dl_mode_p[k-1];
        end
    end

    assign w_exit_vld = r_dl_vld_p[LAT];

    // Operations in the core: up on issue, down when the delay line exits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue, w_exit_vld})
                2'b10:   r_inflight <= r_inflight + OCW'(1);
                2'b01:   r_inflight <= r_inflight - OCW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // After reset, the core may still emit ready pulses for work that was
    // discarded; for LAT cycles a ready with an empty exit stage is ignored.
    always_ff @(posedge clk) begin
        if (rst)
            r_quiet <= QW'(LAT);
        else if (r_quiet != '0)
            r_quiet <= r_quiet - QW'(1);
    end

    assign w_sync_bad = (c_ready != w_exit_vld) && !((r_quiet != '0) && !w_exit_vld);

    // Sticky synchronisation error flag.
    always_ff @(posedge clk) begin
        if (rst)
            r_err_sync <= 1'b0;
        else if (w_sync_bad)
            r_err_sync <= 1'b1;
    end

    assign err_sync = r_err_sync;

    // Capture follows the delay line, not c_ready, so a missing or spurious
    // ready never corrupts FIFO bookkeeping.
    assign w_out_push  = w_exit_vld;
    assign w_out_pop   = m_valid && m_ready;
    assign w_out_wdata = {c_r, c_a, r_dl_tag_p[LAT], r_dl_mode_p[LAT]};
    assign w_out_empty = (r_out_cnt == '0);

    // Output FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_wr  <= '0;
            r_out_rd  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_out_push) r_out_wr <= r_out_wr + OPW'(1);
            if (w_out_pop)  r_out_rd <= r_out_rd + OPW'(1);
            if (w_out_push && !w_out_pop)
                r_out_cnt <= r_out_cnt + OCW'(1);
            else if (!w_out_push && w_out_pop)
                r_out_cnt <= r_out_cnt - OCW'(1);
        end
    end

    // Output FIFO storage (data only, no reset needed).
    always_ff @(posedge clk) begin
        if (w_out_push) r_out_mem[r_out_wr] <= w_out_wdata;
    end

    // Head fields are masked to zero when empty so outputs read 0 after reset.
    assign {w_oh_r, w_oh_a, w_oh_tag, w_oh_mode} = r_out_mem[r_out_rd];
    assign m_valid = !w_out_empty;
    assign m_r     = w_out_empty ? '0 : w_oh_r;
    assign m_a     = w_out_empty ? '0 : w_oh_a;
    assign m_tag   = w_out_empty ? '0 : w_oh_tag;
    assign m_mode  = w_out_empty ? '0 : w_oh_mode;

    assign busy = !w_in_empty || (r_inflight != '0) || !w_out_empty;

`ifdef CORDIC_SCHED_BADMODE_EN
    // Sticky flag for handshaken requests carrying an unsupported mode.
    always_ff @(posedge clk) begin
        if (rst)
            r_bad_mode <= 1'b0;
        else if (s_valid && s_ready && !w_mode_ok)
            r_bad_mode <= 1'b1;
    end
`endif

endmodule
